// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: FSM state encoding and default frame length.
// Bit order is selected at build time with SPI_RX_MSB_FIRST_EN (undefined = LSB-first).
package spi_pkg;

   localparam int SPI_DATA_W      = 12;
   localparam int SPI_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      WAIT_CS = 2'd2
   } spi_state_e;

   // Cycles after reset release before the synchronized cs level reflects the real pin.
   function automatic int flush_cycles(input int sync_stages);
      return sync_stages + 1;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a registered previous value
// giving single-cycle rise/fall strobes. All flops reset to 1 (cs idle level).
module spi_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver (mode 0 sampling on sclk rise) oversampled by the system clock.
// Build option SPI_RX_MSB_FIRST_EN: defined = MSB-first, undefined = LSB-first.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int DATA_W      = SPI_DATA_W,
   parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              frame_err
);

   localparam int CNT_W   = $clog2(DATA_W + 1);
   localparam int FLUSH   = flush_cycles(SYNC_STAGES);
   localparam int FLUSH_W = $clog2(FLUSH + 1);
   localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(FLUSH);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk     (clk),
      .rst     (rst),
      .d_i     (sclk),
      .level_o (sclk_level),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk     (clk),
      .rst     (rst),
      .d_i     (cs),
      .level_o (cs_level),
      .rise_o  (cs_rise),
      .fall_o  (cs_fall)
   );

   spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk     (clk),
      .rst     (rst),
      .d_i     (mosi),
      .level_o (mosi_level),
      .rise_o  (mosi_rise),
      .fall_o  (mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_level, sclk_fall, cs_level, mosi_rise, mosi_fall};

   spi_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d, shift_in;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic                done_q, done_d;
   logic                ferr_q, ferr_d;
   logic [FLUSH_W-1:0]  flush_q;
   logic                armed;

   // A cs already low at reset release shows up as a fall while the synchronizer
   // flushes its reset value; falls are ignored until that window has passed.
   always_ff @(posedge clk) begin
      if (rst) begin
         flush_q <= '0;
      end else if (flush_q != FLUSH_END) begin
         flush_q <= flush_q + FLUSH_W'(1);
      end
   end

   assign armed = (flush_q == FLUSH_END);

`ifdef SPI_RX_MSB_FIRST_EN
   assign shift_in = {shift_q[DATA_W-2:0], mosi_level};
`else
   assign shift_in = {mosi_level, shift_q[DATA_W-1:1]};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall && armed) begin
               cnt_d   = '0;
               shift_d = '0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (sclk_rise) begin
               shift_d = shift_in;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BIT) begin
                  // Final bit wins over a simultaneous cs rise; that rise is consumed here.
                  dout_d  = shift_in;
                  done_d  = 1'b1;
                  state_d = cs_rise ? IDLE : WAIT_CS;
               end else if (cs_rise) begin
                  ferr_d  = 1'b1;
                  state_d = IDLE;
               end
            end else if (cs_rise) begin
               ferr_d  = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_CS: begin
            if (cs_rise) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dout      = dout_q;
   assign done      = done_q;
   assign frame_err = ferr_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: expected frames go to a scoreboard queue when driven
// and are popped by a monitor on each done pulse.
module tb_spi_slave_rx;

   localparam int DW = 12;
   localparam int HP = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclk = 1'b0;
   logic          cs = 1'b1;
   logic          mosi = 1'b0;
   logic [DW-1:0] dout;
   logic          done;
   logic          frame_err;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb[$];
   int            ferr_exp = 0;
   logic [DW-1:0] last_exp = '0;

   spi_slave_rx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .cs        (cs),
      .mosi      (mosi),
      .dout      (dout),
      .done      (done),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            logic [DW-1:0] e;
            chk("done_excl_ferr", frame_err, 0);
            chk("done_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               chk("dout", dout, e);
               $display("done  dout=0x%03h expected=0x%03h", dout, e);
            end
         end
         if (frame_err) begin
            chk("ferr_expected", ferr_exp > 0, 1);
            if (ferr_exp > 0) ferr_exp--;
            $display("frame_err  dout=0x%03h", dout);
         end
      end
   end

   function automatic logic [31:0] frame_stream(input logic [DW-1:0] v);
      logic [31:0] s;
      s = '0;
`ifdef SPI_RX_MSB_FIRST_EN
      for (int i = 0; i < DW; i++) s[i] = v[DW-1-i];
`else
      s[DW-1:0] = v;
`endif
      return s;
   endfunction

   task automatic spi_bits(input logic [31:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         mosi = bits[i];
         repeat (HP) @(negedge clk);
         sclk = 1'b1;
         repeat (HP) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs = 1'b0;
      repeat (HP) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (HP) @(negedge clk);
      cs = 1'b1;
      repeat (HP) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 100 && (sb.size() != 0 || ferr_exp != 0); i++) @(negedge clk);
      chk({tag, "_pending_done"}, sb.size(), 0);
      chk({tag, "_pending_ferr"}, ferr_exp, 0);
      sb.delete();
      ferr_exp = 0;
   endtask

   task automatic send_frame(input logic [DW-1:0] v);
      sb.push_back(v);
      last_exp = v;
      cs_low();
      spi_bits(frame_stream(v), DW);
      cs_high();
      drain("frame");
   endtask

   initial begin
      logic [DW-1:0] v;

      // reset with cs held low: must not start a frame after release
      rst = 1'b1;
      cs  = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_dout", dout, 0);
      chk("rst_done", done, 0);
      chk("rst_ferr", frame_err, 0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      spi_bits(32'h1F, 5);
      cs_high();
      drain("cs_low_at_release");
      chk("cs_low_at_release_dout", dout, 0);

      send_frame(12'h0A5);

      for (int k = 0; k < 10; k++) begin
         v = DW'($urandom_range(200, 10));
         send_frame(v);
      end

      // short frame: 7 bits then cs high
      ferr_exp = 1;
      cs_low();
      spi_bits($urandom, 7);
      cs_high();
      drain("short");
      chk("short_hold_dout", dout, last_exp);

      send_frame(12'h0C8);

      // 12 ones then 3 extra zeros that must be ignored
      sb.push_back(12'hFFF);
      last_exp = 12'hFFF;
      cs_low();
      spi_bits(32'h0000_0FFF, 15);
      cs_high();
      drain("overrun");
      chk("overrun_dout", dout, 12'hFFF);

      // reset after the 6th bit
      cs_low();
      spi_bits(frame_stream(12'h123), 6);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_dout", dout, 0);
      chk("midrst_done", done, 0);
      chk("midrst_ferr", frame_err, 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (HP) @(negedge clk);
      drain("midrst");
      chk("midrst_after_dout", dout, 0);

      send_frame(12'h123);

`ifdef SPI_RX_MSB_FIRST_EN
      sb.push_back(12'h801);
      cs_low();
      spi_bits(32'h0000_0801, 12);
      cs_high();
      drain("msb_stream");
      chk("msb_stream_dout", dout, 12'h801);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
